// File: rtl/stream_pkg.sv
// Shared types and helpers for the narrow-to-wide stream upsizer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: default widths, out_w() width helper, lane_keep() thermometer
// mask, the default-shape output word struct and the hold-register states.
package stream_pkg;

  localparam int DEF_IN_W  = 8;
  localparam int DEF_RATIO = 2;
  // Upper bound on lanes that lane_keep() can describe.
  localparam int MAX_RATIO = 32;

  function automatic int out_w(input int in_w, input int ratio);
    return in_w * ratio;
  endfunction

  localparam int DEF_OUT_W = out_w(DEF_IN_W, DEF_RATIO);

  // Thermometer mask: lanes 0..idx set, nothing at or above ratio.
  function automatic logic [MAX_RATIO-1:0] lane_keep(input int idx, input int ratio);
    logic [MAX_RATIO-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_RATIO; i++) begin
      if (i < ratio && i <= idx) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Output word for the default 8->16 configuration. Parameterised
  // instances declare the same shape locally with their own widths.
  typedef struct packed {
    logic [DEF_OUT_W-1:0] data;
    logic [DEF_RATIO-1:0] keep;
    logic                 last;
  } stream_word_t;

  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } hold_state_t;

endpackage

// File: rtl/stream_hold_reg.sv
// Single-entry valid/ready register holding one packed output word.
// Latency: 1 cycle from load to out_vld.
// Backpressure: load_rdy = !out_vld | out_rdy, so a stalled word blocks loads.
// Ports: clk, rst_n (async active-low); load_vld/load_dat/load_rdy (write
// side); out_vld/out_dat/out_rdy (read side).
module stream_hold_reg
  import stream_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_vld,
  input  logic [W-1:0] load_dat,
  output logic         load_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  input  logic         out_rdy
);

  hold_state_t state_q, state_d;
  logic        load_go;

  assign out_vld  = (state_q == HOLD_FULL);
  // Retiring and loading in the same edge is allowed, so a draining word
  // does not cost a bubble.
  assign load_rdy = ~out_vld | out_rdy;
  assign load_go  = load_vld & load_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HOLD_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HOLD_EMPTY: if (load_go) state_d = HOLD_FULL;
      HOLD_FULL: begin
        if (load_go)      state_d = HOLD_FULL;
        else if (out_rdy) state_d = HOLD_EMPTY;
      end
      default: state_d = HOLD_EMPTY;
    endcase
  end

  // Payload only moves on a load, which keeps it stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       out_dat <= '0;
    else if (load_go) out_dat <= load_dat;
  end

endmodule

// File: rtl/stream_upsizer.sv
// Packs RATIO narrow beats (lane 0 first) into one wide word with keep/last.
// Latency: 1 cycle from the closing beat to out_valid; one beat per cycle.
// Backpressure: in_ready = !out_valid | out_ready; a stalled word stalls input.
// Ports: clk, rst_n (async active-low); in_data/in_valid/in_last/in_ready
// narrow side; out_data/out_keep/out_last/out_valid/out_ready wide side.
// Build option: define STREAM_UPSIZER_BIG_ENDIAN_EN to place the first beat
// in the most significant lane instead of the least significant one.
module stream_upsizer
  import stream_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int RATIO = 2     // must be >= 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [IN_W-1:0]         in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [IN_W*RATIO-1:0]   out_data,
  output logic [RATIO-1:0]        out_keep,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int OUT_W = out_w(IN_W, RATIO);
  localparam int IDX_W = $clog2(RATIO);
  localparam int WORD_W = OUT_W + RATIO + 1;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [RATIO-1:0] keep;
    logic             last;
  } word_t;

  logic [IDX_W-1:0] idx_q;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             hold_rdy;
  logic             in_xfer;
  logic             closing;
  logic [RATIO-1:0] keep_lin;
  logic [RATIO-1:0] keep_lane;
  int               lane;
  word_t            word_ld;
  word_t            word_out;
  logic [WORD_W-1:0] word_out_bits;

  assign in_ready = hold_rdy;
  assign in_xfer  = in_valid & hold_rdy;
  assign closing  = in_xfer & ((idx_q == IDX_W'(RATIO - 1)) | in_last);
  // Keep counted in beat order; remapped to physical lanes below.
  assign keep_lin = RATIO'(lane_keep(int'(idx_q), RATIO));

  always_comb begin
    acc_d     = acc_q;
    keep_lane = keep_lin;
`ifdef STREAM_UPSIZER_BIG_ENDIAN_EN
    lane = RATIO - 1 - int'(idx_q);
    for (int i = 0; i < RATIO; i++) keep_lane[i] = keep_lin[RATIO-1-i];
`else
    lane = int'(idx_q);
`endif
    acc_d[lane*IN_W +: IN_W] = in_data;
  end

  // The accumulator is cleared on every close, so unfilled lanes are
  // already zero; the mask makes the zero-fill explicit at the word boundary.
  always_comb begin
    word_ld      = '0;
    word_ld.keep = keep_lane;
    word_ld.last = in_last;
    for (int i = 0; i < RATIO; i++) begin
      word_ld.data[i*IN_W +: IN_W] = keep_lane[i] ? acc_d[i*IN_W +: IN_W] : '0;
    end
  end

  // idx never passes RATIO-1: that beat always closes and resets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      acc_q <= '0;
    end else if (in_xfer) begin
      if (closing) begin
        idx_q <= '0;
        acc_q <= '0;
      end else begin
        idx_q <= idx_q + 1'b1;
        acc_q <= acc_d;
      end
    end
  end

  stream_hold_reg #(
    .W (WORD_W)
  ) u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_vld (closing),
    .load_dat (word_ld),
    .load_rdy (hold_rdy),
    .out_vld  (out_valid),
    .out_dat  (word_out_bits),
    .out_rdy  (out_ready)
  );

  assign word_out = word_out_bits;
  assign out_data = word_out.data;
  assign out_keep = word_out.keep;
  assign out_last = word_out.last;

endmodule
